// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Data is zero-extended to 9 bits; the padding does not change the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input parity_e mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: return p;
      PAR_ODD:  return ~p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-clk tick every BAUD_DIV clks (16x oversample rate).
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_core_param.sv
// Single-clock full-duplex UART: holding-register TX, 16x oversampled RX,
// optional parity, loopback, and sticky framing/parity/overrun flags.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BAUD_DIV  = 16,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_enable,
  output logic              tx_out,
  output logic              tx_empty,
  input  logic              uld_rx_data,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_enable,
  input  logic              rx_in,
  output logic              rx_empty,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun,
  input  logic              loopback
);

  localparam parity_e    PAR_MODE  = parity_e'(2'(PARITY));
  localparam bit         HAS_PAR   = (PARITY != 0);
  localparam logic [3:0] OS_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_HALF   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  logic tick;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_e         tx_state, tx_state_nxt;
  logic [DATA_W-1:0] tx_hold, tx_shift;
  logic              tx_par, tx_bit_end, tx_go;
  logic [3:0]        tx_os_cnt, tx_bit_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_state <= TX_IDLE;
    else          tx_state <= tx_state_nxt;
  end

  // The stop-bit exit may go straight to START so back-to-back frames have no idle gap.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_go        = 1'b0;
    tx_bit_end   = tick && (tx_os_cnt == OS_LAST);
    case (tx_state)
      TX_IDLE:   if (tick && !tx_empty && tx_enable) begin
                   tx_state_nxt = TX_START;
                   tx_go        = 1'b1;
                 end
      TX_START:  if (tx_bit_end) tx_state_nxt = TX_DATA;
      TX_DATA:   if (tx_bit_end && tx_bit_cnt == DATA_LAST)
                   tx_state_nxt = HAS_PAR ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_state_nxt = TX_STOP;
      TX_STOP:   if (tx_bit_end && tx_bit_cnt == STOP_LAST) begin
                   if (!tx_empty && tx_enable) begin
                     tx_state_nxt = TX_START;
                     tx_go        = 1'b1;
                   end else begin
                     tx_state_nxt = TX_IDLE;
                   end
                 end
      default:   tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_out = 1'b1;
    case (tx_state)
      TX_START:  tx_out = 1'b0;
      TX_DATA:   tx_out = tx_shift[0];
      TX_PARITY: tx_out = tx_par;
      default:   tx_out = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_hold    <= '0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      tx_empty   <= 1'b1;
      tx_os_cnt  <= '0;
      tx_bit_cnt <= '0;
    end else begin
      if (tx_go) begin
        tx_shift <= tx_hold;
        tx_par   <= calc_parity(9'(tx_hold), PAR_MODE);
        tx_empty <= 1'b1;
      end else begin
        if (ld_tx_data && tx_empty) begin
          tx_hold  <= tx_data;
          tx_empty <= 1'b0;
        end
        if (tx_state == TX_DATA && tx_bit_end) tx_shift <= tx_shift >> 1;
      end
      if (tx_go || tx_state == TX_IDLE) tx_os_cnt <= '0;
      else if (tick)                    tx_os_cnt <= tx_os_cnt + 1'b1;
      if (tx_state_nxt != tx_state)     tx_bit_cnt <= '0;
      else if (tx_bit_end)              tx_bit_cnt <= tx_bit_cnt + 1'b1;
    end
  end

  // ---------------- receiver ----------------
  rx_state_e         rx_state, rx_state_nxt;
  logic              rx_sync1, rx_sync2, rx_prev, rx_bit, rx_mid;
  logic [3:0]        rx_os_cnt, rx_bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_par_pend, rx_frame_pend, rx_deliver;

  assign rx_bit = loopback ? tx_out : rx_sync2;
  assign rx_mid = tick && (rx_os_cnt == OS_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_state <= RX_IDLE;
    else          rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_prev && !rx_bit) rx_state_nxt = RX_START;
      RX_START:  if (tick && rx_os_cnt == OS_HALF)
                   rx_state_nxt = rx_bit ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_mid && rx_bit_cnt == DATA_LAST)
                   rx_state_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_mid) rx_state_nxt = RX_STOP;
      RX_STOP:   if (rx_mid) rx_state_nxt = RX_IDLE;
      default:   rx_state_nxt = RX_IDLE;
    endcase
    if (!rx_enable) rx_state_nxt = RX_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync1      <= 1'b1;
      rx_sync2      <= 1'b1;
      rx_prev       <= 1'b1;
      rx_os_cnt     <= '0;
      rx_bit_cnt    <= '0;
      rx_shift      <= '0;
      rx_par_pend   <= 1'b0;
      rx_frame_pend <= 1'b0;
      rx_deliver    <= 1'b0;
    end else begin
      rx_sync1   <= rx_in;
      rx_sync2   <= rx_sync1;
      rx_prev    <= rx_bit;
      rx_deliver <= rx_enable && rx_state == RX_STOP && rx_mid;
      // Restarting the count on every state change puts later samples at mid-bit.
      if (rx_state_nxt != rx_state || rx_state == RX_IDLE) rx_os_cnt <= '0;
      else if (tick)                                       rx_os_cnt <= rx_os_cnt + 1'b1;
      if (rx_state_nxt != rx_state) rx_bit_cnt <= '0;
      else if (rx_mid)              rx_bit_cnt <= rx_bit_cnt + 1'b1;
      if (rx_state == RX_START) rx_par_pend <= 1'b0;
      if (rx_state == RX_DATA && rx_mid) rx_shift <= {rx_bit, rx_shift[DATA_W-1:1]};
      if (rx_state == RX_PARITY && rx_mid)
        rx_par_pend <= (rx_bit != calc_parity(9'(rx_shift), PAR_MODE));
      if (rx_state == RX_STOP && rx_mid) rx_frame_pend <= ~rx_bit;
    end
  end

  // An unload in the delivery clk frees the buffer first, so the new word lands cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data       <= '0;
      rx_empty      <= 1'b1;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (rx_deliver && (rx_empty || uld_rx_data)) begin
      rx_data       <= rx_shift;
      rx_empty      <= 1'b0;
      rx_frame_err  <= rx_frame_pend;
      rx_parity_err <= rx_par_pend;
      rx_overrun    <= 1'b0;
    end else if (rx_deliver) begin
      rx_overrun <= 1'b1;
    end else if (uld_rx_data && !rx_empty) begin
      rx_empty      <= 1'b1;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench: three instances (no/even/odd parity) share stimulus, BAUD_DIV=2.
module tb_uart_core_param;

  localparam int BIT = 32;

  logic       clk = 1'b0;
  logic       reset_n, ld_tx_data, tx_enable, uld_rx_data, rx_enable, rx_in, loopback;
  logic [7:0] tx_data;
  logic [2:0] tx_out_v, tx_empty_v, rx_empty_v, fe_v, pe_v, ov_v;
  logic [7:0] rx_data_v [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_core_param #(.DATA_W(8), .BAUD_DIV(2), .PARITY(g), .STOP_BITS(1)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ld_tx_data    (ld_tx_data),
      .tx_data       (tx_data),
      .tx_enable     (tx_enable),
      .tx_out        (tx_out_v[g]),
      .tx_empty      (tx_empty_v[g]),
      .uld_rx_data   (uld_rx_data),
      .rx_data       (rx_data_v[g]),
      .rx_enable     (rx_enable),
      .rx_in         (rx_in),
      .rx_empty      (rx_empty_v[g]),
      .rx_frame_err  (fe_v[g]),
      .rx_parity_err (pe_v[g]),
      .rx_overrun    (ov_v[g]),
      .loopback      (loopback)
    );
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; ld_tx_data = 1'b0; tx_data = '0; tx_enable = 1'b1;
    uld_rx_data = 1'b0; rx_enable = 1'b1; rx_in = 1'b1; loopback = 1'b0;
    tick_n(3);
    reset_n = 1'b1;
    tick_n(2);
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    ld_tx_data = 1'b1;
    @(negedge clk);
    ld_tx_data = 1'b0;
  endtask

  task automatic wait_tx_start(input int idx, input string tag);
    int i;
    for (i = 0; i < 2000 && tx_out_v[idx] !== 1'b0; i++) @(negedge clk);
    check(tag, 16'(i < 2000), 16'd1);
  endtask

  task automatic wait_tx_free(input string tag);
    int i;
    for (i = 0; i < 2000 && tx_empty_v[0] !== 1'b1; i++) @(negedge clk);
    check(tag, 16'(i < 2000), 16'd1);
  endtask

  task automatic wait_rx(input int idx, input int max, input string tag);
    int i;
    for (i = 0; i < max && rx_empty_v[idx] !== 1'b0; i++) @(negedge clk);
    check(tag, 16'(i < max), 16'd1);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par,
                            input logic stop);
    rx_in = 1'b0;
    tick_n(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      tick_n(BIT);
    end
    if (has_par) begin
      rx_in = par;
      tick_n(BIT);
    end
    rx_in = stop;
    tick_n(BIT);
    rx_in = 1'b1;
    tick_n(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] exp_seq;
    int i;

    // 1: reset state, then loopback frame 0xA5
    apply_reset();
    check("rst_tx_out",   16'(tx_out_v[0]),   16'd1);
    check("rst_tx_empty", 16'(tx_empty_v[0]), 16'd1);
    check("rst_rx_empty", 16'(rx_empty_v[0]), 16'd1);
    check("rst_rx_data",  16'(rx_data_v[0]),  16'h00);
    check("rst_fe",       16'(fe_v[0]),       16'd0);
    check("rst_pe",       16'(pe_v[0]),       16'd0);
    check("rst_ov",       16'(ov_v[0]),       16'd0);
    loopback = 1'b1;
    load(8'hA5);
    check("t1_tx_empty_ld", 16'(tx_empty_v[0]), 16'd0);
    wait_tx_start(0, "t1_start");
    check("t1_tx_empty_go", 16'(tx_empty_v[0]), 16'd1);
    exp_seq = 10'b1101001010;
    tick_n(16);
    for (int b = 0; b < 10; b++) begin
      check($sformatf("t1_bit%0d", b), 16'(tx_out_v[0]), 16'(exp_seq[b]));
      tick_n(BIT);
    end
    wait_rx(0, 400, "t1_rx_wait");
    check("t1_rx_data", 16'(rx_data_v[0]), 16'hA5);
    check("t1_flags",   16'({fe_v[0], pe_v[0], ov_v[0]}), 16'd0);

    // 2: parity bit generation and a corrupted parity bit on rx_in
    apply_reset();
    loopback = 1'b1;
    load(8'h07);
    wait_tx_start(1, "t2_start");
    tick_n(16 + 9 * BIT);
    check("t2_even_par_bit", 16'(tx_out_v[1]), 16'd1);
    check("t2_odd_par_bit",  16'(tx_out_v[2]), 16'd0);
    wait_rx(1, 400, "t2_rx_wait");
    check("t2_even_lb_data", 16'(rx_data_v[1]), 16'h07);
    check("t2_even_lb_pe",   16'(pe_v[1]),      16'd0);
    check("t2_odd_lb_data",  16'(rx_data_v[2]), 16'h07);
    check("t2_odd_lb_pe",    16'(pe_v[2]),      16'd0);
    apply_reset();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    wait_rx(1, 200, "t2_bad_wait");
    check("t2_bad_pe",      16'(pe_v[1]),      16'd1);
    check("t2_bad_data",    16'(rx_data_v[1]), 16'h07);
    check("t2_bad_fe",      16'(fe_v[1]),      16'd0);
    check("t2_odd_ok_pe",   16'(pe_v[2]),      16'd0);
    check("t2_odd_ok_data", 16'(rx_data_v[2]), 16'h07);

    // 3: framing error, then unload clears it
    apply_reset();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_rx(0, 200, "t3_rx_wait");
    check("t3_fe",      16'(fe_v[0]),      16'd1);
    check("t3_data",    16'(rx_data_v[0]), 16'h3C);
    check("t3_pe",      16'(pe_v[0]),      16'd0);
    uld_rx_data = 1'b1;
    @(negedge clk);
    uld_rx_data = 1'b0;
    check("t3_uld_empty", 16'(rx_empty_v[0]), 16'd1);
    check("t3_uld_fe",    16'(fe_v[0]),       16'd0);

    // 4a: two back-to-back frames without unload -> overrun
    apply_reset();
    loopback = 1'b1;
    load(8'h11);
    wait_tx_free("t4_free1");
    load(8'h22);
    wait_rx(0, 800, "t4_rx1_wait");
    check("t4_rx1_data", 16'(rx_data_v[0]), 16'h11);
    for (i = 0; i < 500 && ov_v[0] !== 1'b1; i++) @(negedge clk);
    check("t4_ov",       16'(ov_v[0]),       16'd1);
    check("t4_ov_data",  16'(rx_data_v[0]),  16'h11);
    check("t4_ov_empty", 16'(rx_empty_v[0]), 16'd0);

    // 4b: unload in the second frame's delivery clk (frames are exactly 320 clks apart)
    apply_reset();
    loopback = 1'b1;
    load(8'h11);
    wait_tx_free("t4b_free1");
    load(8'h22);
    wait_rx(0, 800, "t4b_rx1_wait");
    check("t4b_rx1_data", 16'(rx_data_v[0]), 16'h11);
    tick_n(319);
    uld_rx_data = 1'b1;
    @(negedge clk);
    uld_rx_data = 1'b0;
    check("t4b_data",  16'(rx_data_v[0]),  16'h22);
    check("t4b_empty", 16'(rx_empty_v[0]), 16'd0);
    check("t4b_ov",    16'(ov_v[0]),       16'd0);
    tick_n(40);
    check("t4b_ov_late", 16'(ov_v[0]), 16'd0);

    // 5: short low glitch is a false start; receiver still works afterwards
    apply_reset();
    rx_in = 1'b0;
    tick_n(8);
    rx_in = 1'b1;
    tick_n(400);
    check("t5_empty", 16'(rx_empty_v[0]), 16'd1);
    check("t5_flags", 16'({fe_v[0], pe_v[0], ov_v[0]}), 16'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_rx(0, 200, "t5_rx_wait");
    check("t5_data", 16'(rx_data_v[0]), 16'h3C);
    check("t5_fe",   16'(fe_v[0]),      16'd0);

    // 6: asynchronous reset mid-DATA, then a clean 0x5A frame
    apply_reset();
    loopback = 1'b1;
    load(8'h5A);
    wait_tx_start(0, "t6_start");
    load(8'h5A);
    tick_n(99);
    check("t6_pre_tx_out",   16'(tx_out_v[0]),   16'd0);
    check("t6_pre_tx_empty", 16'(tx_empty_v[0]), 16'd0);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_tx_out",   16'(tx_out_v[0]),   16'd1);
    check("t6_rst_tx_empty", 16'(tx_empty_v[0]), 16'd1);
    check("t6_rst_rx_empty", 16'(rx_empty_v[0]), 16'd1);
    tick_n(2);
    reset_n = 1'b1;
    tick_n(2);
    check("t6_idle_tx_out", 16'(tx_out_v[0]), 16'd1);
    load(8'h5A);
    wait_rx(0, 800, "t6_rx_wait");
    check("t6_data",  16'(rx_data_v[0]), 16'h5A);
    check("t6_flags", 16'({fe_v[0], pe_v[0], ov_v[0]}), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
